// File: rtl/turn_controller.sv
// Two-player card duel controller: button edge detection, turn sequencing,
// commit validation, round scoring and end-of-game resolution.
module turn_controller #(
  parameter int WIN_TARGET = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_start,
  input  logic       btn_confirm,
  input  logic       btn_abort,
  input  logic [8:0] sel,
  output logic [2:0] state,
  output logic       active_p2,
  output logic [8:0] p1_avail,
  output logic [8:0] p2_avail,
  output logic [3:0] p1_card,
  output logic [3:0] p2_card,
  output logic       lead_black,
  output logic [3:0] round,
  output logic [3:0] p1_wins,
  output logic [3:0] p2_wins,
  output logic [1:0] match_result,
  output logic       game_over,
  output logic [1:0] game_result,
  output logic       sel_error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_SHOW   = 3'b001,
    S_LEAD   = 3'b010,
    S_FOLLOW = 3'b011,
    S_MATCH  = 3'b100,
    S_OVER   = 3'b101
  } state_e;

  localparam logic [3:0] WIN_T = 4'(WIN_TARGET);

  state_e     state_q, state_d;
  logic       lead_p2_q, lead_p2_d;
  logic [8:0] p1_av_q, p1_av_d;
  logic [8:0] p2_av_q, p2_av_d;
  logic [3:0] p1_card_q, p1_card_d;
  logic [3:0] p2_card_q, p2_card_d;
  logic [3:0] round_q, round_d;
  logic [3:0] p1_wins_q, p1_wins_d;
  logic [3:0] p2_wins_q, p2_wins_d;
  logic [1:0] match_q, match_d;
  logic [1:0] result_q, result_d;
  logic       sel_err_q, sel_err_d;
  logic       start_q, confirm_q, abort_q;

  logic       ev_abort, ev_confirm, ev_start;
  logic       act_p2;
  logic       commit_ok;
  logic [3:0] sel_val;
  logic [3:0] c1, c2;
  logic       clear;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= 4'd9) ? v : v + 4'd1;
  endfunction

  // Lower-priority events are masked by any higher one on the same edge
  assign ev_abort   = btn_abort & ~abort_q;
  assign ev_confirm = btn_confirm & ~confirm_q & ~ev_abort;
  assign ev_start   = btn_start & ~start_q & ~ev_abort & ~btn_confirm_ev_raw();

  function automatic logic btn_confirm_ev_raw();
    return btn_confirm & ~confirm_q;
  endfunction

  assign game_over = (round_q == 4'd9) |
                     (p1_wins_q >= WIN_T) |
                     (p2_wins_q >= WIN_T);

  always_comb begin
    act_p2 = 1'b0;
    if (state_q == S_LEAD)   act_p2 = lead_p2_q;
    if (state_q == S_FOLLOW) act_p2 = ~lead_p2_q;
  end

  always_comb begin
    sel_val = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (sel[k]) sel_val = 4'(k);
    end
  end

  assign commit_ok = $onehot(sel) &&
                     ((sel & (act_p2 ? p2_av_q : p1_av_q)) != 9'd0);

  assign c1 = lead_p2_q ? sel_val : p1_card_q;
  assign c2 = lead_p2_q ? p2_card_q : sel_val;

  always_comb begin
    state_d   = state_q;
    lead_p2_d = lead_p2_q;
    p1_av_d   = p1_av_q;
    p2_av_d   = p2_av_q;
    p1_card_d = p1_card_q;
    p2_card_d = p2_card_q;
    round_d   = round_q;
    p1_wins_d = p1_wins_q;
    p2_wins_d = p2_wins_q;
    match_d   = match_q;
    result_d  = result_q;
    sel_err_d = 1'b0;
    clear     = 1'b0;

    unique case (1'b1)
      ev_abort: begin
        if (state_q != S_IDLE) begin
          clear   = 1'b1;
          state_d = S_IDLE;
        end
      end
      ev_confirm: begin
        unique case (state_q)
          S_SHOW: state_d = S_LEAD;
          S_LEAD, S_FOLLOW: begin
            if (!commit_ok) begin
              sel_err_d = 1'b1;
            end else begin
              if (act_p2) begin
                p2_card_d = sel_val;
                p2_av_d   = p2_av_q & ~sel;
              end else begin
                p1_card_d = sel_val;
                p1_av_d   = p1_av_q & ~sel;
              end
              if (state_q == S_LEAD) begin
                state_d = S_FOLLOW;
              end else begin
                state_d = S_MATCH;
                round_d = sat_inc(round_q);
                if (c1 > c2) begin
                  match_d   = 2'b01;
                  p1_wins_d = sat_inc(p1_wins_q);
                  lead_p2_d = 1'b0;
                end else if (c2 > c1) begin
                  match_d   = 2'b10;
                  p2_wins_d = sat_inc(p2_wins_q);
                  lead_p2_d = 1'b1;
                end else begin
                  match_d   = 2'b11;
                end
              end
            end
          end
          S_MATCH: begin
            if (game_over) begin
              state_d = S_OVER;
              if (p1_wins_q > p2_wins_q)      result_d = 2'b01;
              else if (p2_wins_q > p1_wins_q) result_d = 2'b10;
              else                            result_d = 2'b11;
            end else begin
              state_d = S_SHOW;
            end
          end
          default: ;
        endcase
      end
      ev_start: begin
        if (state_q == S_IDLE) begin
          clear   = 1'b1;
          state_d = S_SHOW;
        end else if (state_q == S_OVER) begin
          clear   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase

    if (clear) begin
      lead_p2_d = 1'b0;
      p1_av_d   = 9'h1FF;
      p2_av_d   = 9'h1FF;
      p1_card_d = 4'd0;
      p2_card_d = 4'd0;
      round_d   = 4'd0;
      p1_wins_d = 4'd0;
      p2_wins_d = 4'd0;
      match_d   = 2'b00;
      result_d  = 2'b00;
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      lead_p2_q <= 1'b0;
      p1_av_q   <= 9'h1FF;
      p2_av_q   <= 9'h1FF;
      p1_card_q <= 4'd0;
      p2_card_q <= 4'd0;
      round_q   <= 4'd0;
      p1_wins_q <= 4'd0;
      p2_wins_q <= 4'd0;
      match_q   <= 2'b00;
      result_q  <= 2'b00;
      sel_err_q <= 1'b0;
      start_q   <= 1'b0;
      confirm_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lead_p2_q <= lead_p2_d;
      p1_av_q   <= p1_av_d;
      p2_av_q   <= p2_av_d;
      p1_card_q <= p1_card_d;
      p2_card_q <= p2_card_d;
      round_q   <= round_d;
      p1_wins_q <= p1_wins_d;
      p2_wins_q <= p2_wins_d;
      match_q   <= match_d;
      result_q  <= result_d;
      sel_err_q <= sel_err_d;
      start_q   <= btn_start;
      confirm_q <= btn_confirm;
      abort_q   <= btn_abort;
    end
  end

  assign state        = state_q;
  assign active_p2    = act_p2;
  assign p1_avail     = p1_av_q;
  assign p2_avail     = p2_av_q;
  assign p1_card      = p1_card_q;
  assign p2_card      = p2_card_q;
  assign lead_black   = lead_p2_q ? p2_card_q[0] : p1_card_q[0];
  assign round        = round_q;
  assign p1_wins      = p1_wins_q;
  assign p2_wins      = p2_wins_q;
  assign match_result = match_q;
  assign game_result  = result_q;
  assign sel_error    = sel_err_q;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: directed game scenarios plus random play
// checked against a rule-level model of the game.
module tb_turn_controller;

  localparam int WT = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       bs = 1'b0, bc = 1'b0, ba = 1'b0;
  logic [8:0] sel = 9'd0;

  logic [2:0] state;
  logic       active_p2, lead_black, game_over, sel_error;
  logic [8:0] p1_avail, p2_avail;
  logic [3:0] p1_card, p2_card, round, p1_wins, p2_wins;
  logic [1:0] match_result, game_result;

  always #5 clk = ~clk;

  turn_controller #(.WIN_TARGET(WT)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_start(bs), .btn_confirm(bc), .btn_abort(ba),
    .sel(sel), .state(state), .active_p2(active_p2),
    .p1_avail(p1_avail), .p2_avail(p2_avail),
    .p1_card(p1_card), .p2_card(p2_card),
    .lead_black(lead_black), .round(round),
    .p1_wins(p1_wins), .p2_wins(p2_wins),
    .match_result(match_result), .game_over(game_over),
    .game_result(game_result), .sel_error(sel_error)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Game model: players indexed 0 (P1) and 1 (P2)
  int       m_st, m_lead, m_round, m_match, m_res;
  int       m_wins[2];
  int       m_card[2];
  bit [8:0] m_av[2];
  bit       m_err, h_s, h_c, h_a;

  task automatic m_clear();
    m_lead = 0; m_round = 0; m_match = 0; m_res = 0; m_err = 0;
    for (int p = 0; p < 2; p++) begin
      m_wins[p] = 0; m_card[p] = 0; m_av[p] = 9'h1FF;
    end
  endtask

  task automatic m_reset();
    m_clear(); m_st = 0; h_s = 0; h_c = 0; h_a = 0;
  endtask

  function automatic int m_active();
    if (m_st == 2) return m_lead;
    if (m_st == 3) return 1 - m_lead;
    return 0;
  endfunction

  function automatic bit m_over();
    return m_round == 9 || m_wins[0] >= WT || m_wins[1] >= WT;
  endfunction

  task automatic m_step(input bit s, input bit c, input bit a,
                        input bit [8:0] sl);
    bit ea, ec, es;
    int p, k;
    ea = a && !h_a;
    ec = c && !h_c && !ea;
    es = s && !h_s && !ea && !(c && !h_c);
    h_s = s; h_c = c; h_a = a;
    m_err = 0;
    if (ea) begin
      if (m_st != 0) begin m_clear(); m_st = 0; end
    end else if (ec) begin
      if (m_st == 1) m_st = 2;
      else if (m_st == 2 || m_st == 3) begin
        p = m_active();
        if ($countones(sl) != 1 || (sl & m_av[p]) == 0) m_err = 1;
        else begin
          k = 0;
          for (int i = 0; i < 9; i++) if (sl[i]) k = i;
          m_card[p] = k;
          m_av[p][k] = 1'b0;
          if (m_st == 2) m_st = 3;
          else begin
            if (m_card[0] > m_card[1]) begin
              m_match = 1; m_wins[0]++; m_lead = 0;
            end else if (m_card[1] > m_card[0]) begin
              m_match = 2; m_wins[1]++; m_lead = 1;
            end else m_match = 3;
            m_round++;
            m_st = 4;
          end
        end
      end else if (m_st == 4) begin
        if (m_over()) begin
          m_st = 5;
          m_res = (m_wins[0] > m_wins[1]) ? 1 :
                  (m_wins[1] > m_wins[0]) ? 2 : 3;
        end else m_st = 1;
      end
    end else if (es) begin
      if (m_st == 0) begin m_clear(); m_st = 1; end
      else if (m_st == 5) begin m_clear(); m_st = 0; end
    end
  endtask

  task automatic check_all();
    chk("state", state, m_st);
    chk("active_p2", active_p2, m_active());
    chk("p1_avail", p1_avail, m_av[0]);
    chk("p2_avail", p2_avail, m_av[1]);
    chk("p1_card", p1_card, m_card[0]);
    chk("p2_card", p2_card, m_card[1]);
    chk("round", round, m_round);
    chk("p1_wins", p1_wins, m_wins[0]);
    chk("p2_wins", p2_wins, m_wins[1]);
    chk("match_result", match_result, m_match);
    chk("game_over", game_over, m_over());
    chk("game_result", game_result, m_res);
    chk("sel_error", sel_error, m_err);
    if (m_st == 3) chk("lead_black", lead_black, m_card[m_lead] % 2);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_active"}, active_p2, 0);
    chk({tag, "_p1av"}, p1_avail, 9'h1FF);
    chk({tag, "_p2av"}, p2_avail, 9'h1FF);
    chk({tag, "_cards"}, {p1_card, p2_card}, 0);
    chk({tag, "_round"}, round, 0);
    chk({tag, "_wins"}, {p1_wins, p2_wins}, 0);
    chk({tag, "_res"}, {match_result, game_result}, 0);
    chk({tag, "_err"}, sel_error, 0);
  endtask

  task automatic cyc(input bit s, input bit c, input bit a,
                     input bit [8:0] sl);
    @(negedge clk);
    bs = s; bc = c; ba = a; sel = sl;
    @(posedge clk);
    m_step(s, c, a, sl);
    #1 check_all();
  endtask

  task automatic press_c(input bit [8:0] sl);
    cyc(0, 1, 0, sl);
    cyc(0, 0, 0, sl);
  endtask

  task automatic press_s();
    cyc(1, 0, 0, 9'd0);
    cyc(0, 0, 0, 9'd0);
  endtask

  function automatic bit [8:0] pick_sel();
    bit [8:0] av;
    int r, n, j;
    av = m_av[m_active()];
    r = $urandom_range(0, 9);
    if (r < 7 && av != 0) begin
      n = $urandom_range(0, $countones(av) - 1);
      for (int i = 0; i < 9; i++) begin
        if (av[i]) begin
          if (n == 0) j = i;
          n--;
        end
      end
      return 9'h1 << j;
    end
    if (r < 9) return 9'($urandom_range(0, 511));
    return 9'd0;
  endfunction

  initial begin
    m_reset();
    #1 reset_n = 1'b0;
    bs = 1'b1;
    #2 check_reset_vals("por");

    // start held high through reset release yields one event
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    m_step(1, 0, 0, 9'd0);
    #1 check_all();
    chk("held_start", state, 3'b001);
    cyc(0, 0, 0, 9'd0);

    // one round, P1 card 4 beats P2 card 2
    press_c(9'd0);
    press_c(9'h010);
    press_c(9'h004);
    chk("r1_state", state, 3'b100);
    chk("r1_match", match_result, 2'b01);
    chk("r1_p1wins", p1_wins, 1);
    chk("r1_round", round, 1);
    chk("r1_p1av", p1_avail, 9'h1EF);
    chk("r1_p2av", p2_avail, 9'h1FB);
    press_c(9'd0);
    press_c(9'd0);
    chk("r2_lead_state", state, 3'b010);
    chk("r2_active", active_p2, 0);

    // rejected commits: two-hot, then already played
    cyc(0, 1, 0, 9'h030);
    chk("rej1_err", sel_error, 1);
    chk("rej1_state", state, 3'b010);
    chk("rej1_p1av", p1_avail, 9'h1EF);
    cyc(0, 0, 0, 9'h030);
    chk("rej1_err_clr", sel_error, 0);
    cyc(0, 1, 0, 9'h010);
    chk("rej2_err", sel_error, 1);
    chk("rej2_state", state, 3'b010);
    cyc(0, 0, 0, 9'h010);
    chk("rej2_err_clr", sel_error, 0);

    // draw on card 3
    press_c(9'h008);
    press_c(9'h008);
    chk("draw_match", match_result, 2'b11);
    chk("draw_wins", {p1_wins, p2_wins}, {4'd1, 4'd0});
    chk("draw_round", round, 2);
    press_c(9'd0);
    press_c(9'd0);
    chk("draw_active", active_p2, 0);

    // abort beats confirm in FOLLOW
    press_c(9'h001);
    chk("ab_follow", state, 3'b011);
    cyc(0, 1, 1, 9'h002);
    check_reset_vals("abort");
    cyc(0, 0, 0, 9'd0);

    // P2 wins five straight rounds
    press_s();
    for (int i = 0; i < 5; i++) begin
      press_c(9'd0);
      if (i == 0) begin
        press_c(9'h1 << i);
        press_c(9'h1 << (i + 4));
      end else begin
        press_c(9'h1 << (i + 4));
        press_c(9'h1 << i);
      end
      chk("p2run_match", match_result, 2'b10);
      if (i < 4) begin
        chk("p2run_notover", game_over, 0);
        press_c(9'd0);
      end
    end
    chk("p2run_over", game_over, 1);
    chk("p2run_wins", p2_wins, 5);
    press_c(9'd0);
    chk("p2run_state", state, 3'b101);
    chk("p2run_result", game_result, 2'b10);
    press_s();
    chk("p2run_idle", state, 3'b000);

    // asynchronous reset in the middle of FOLLOW
    press_s();
    press_c(9'd0);
    press_c(9'h100);
    chk("ar_follow", state, 3'b011);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("async");
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // random play
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 99) == 0), pick_sel());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
